// File: rtl/fp_div_if.sv
// fp_div_if: handshake bundle for the sequential fixed-point divider.
//
// Operands are Q(int_w.frac_w) two's complement, W = int_w + frac_w bits.
//   in_valid / in_ready   : operand handshake (a = dividend, b = divisor)
//   out_valid / out_ready : result handshake
//   quotient              : signed result, same Q format as the operands
//   ovf                   : result saturated because it was out of range
//   dz                    : divisor was zero
// The master modport is the side that supplies operands and takes results;
// the slave modport is the divider itself.
interface fp_div_if #(
  parameter int int_w  = 6,
  parameter int frac_w = 8
);
  localparam int W = int_w + frac_w;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic         ovf;
  logic         dz;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, quotient, ovf, dz
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, quotient, ovf, dz
  );
endinterface

// File: rtl/fp_div.sv
// fp_div: sequential signed fixed-point divider, Q(int_w.frac_w) in and out.
//
// Restoring division on magnitudes, one quotient bit per clock. The dividend
// magnitude is pre-scaled by 2^frac_w so the integer quotient lands directly
// in Q(int_w.frac_w); the result is truncated toward zero, then signed and
// saturated. Latency is a constant N = W + frac_w steps, divide-by-zero
// included.
//
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-high; aborts any operation in flight
//   io     : fp_div_if.slave (operand/result handshakes, quotient, ovf, dz)
//
// in_ready and out_valid come straight from flops, so no input reaches an
// output combinationally.
module fp_div #(
  parameter int int_w  = 6,
  parameter int frac_w = 8
) (
  input  logic   clk,
  input  logic   reset,
  fp_div_if.slave io
);
  localparam int W  = int_w + frac_w;
  localparam int N  = W + frac_w;
  localparam int CW = $clog2(N + 1);

  localparam logic [CW-1:0] LAST  = CW'(N - 1);
  localparam logic [W-1:0]  Q_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  Q_MIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Operation context latched at acceptance.
  logic          sa_q, sb_q;
  logic [W-1:0]  mag_b_q;
  logic [N-1:0]  num_q;      // scaled dividend, shifted out MSB first
  logic [W-1:0]  rem_q;      // partial remainder, always < |b| (or junk when dz)
  logic [N-1:0]  qm_q;       // raw quotient magnitude being built
  logic [CW-1:0] cnt_q;

  // Registered outputs.
  logic          in_ready_q;
  logic          out_valid_q;
  logic [W-1:0]  quotient_q;
  logic          ovf_q;
  logic          dz_q;

  // Combinational datapath signals.
  logic [W-1:0]  mag_a;
  logic [W-1:0]  mag_b;
  logic [W:0]    rem_shift;
  logic          q_bit;
  logic [W-1:0]  rem_next;
  logic [N-1:0]  qm_next;
  logic          neg;
  logic [W-1:0]  res_q;
  logic          res_ovf;

  // Operand magnitudes. Negating the most negative value wraps back to
  // 2^(W-1), which is exactly the unsigned magnitude we want.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    mag_a = io.a;
    mag_b = io.b;
    if (io.a[W-1]) mag_a = -io.a;
    if (io.b[W-1]) mag_b = -io.b;
  end

  // One restoring step: bring down the next numerator bit, subtract the
  // divisor when it fits. The shifted remainder needs one extra bit since
  // the old remainder can be as large as 2^(W-1)-1.
  always_comb begin
    rem_shift = {rem_q, num_q[N-1]};
    q_bit     = (rem_shift >= {1'b0, mag_b_q});
    rem_next  = q_bit ? W'(rem_shift - {1'b0, mag_b_q}) : W'(rem_shift);
    qm_next   = {qm_q[N-2:0], q_bit};
  end

  // Result formation from the final magnitude. Saturation is judged on the
  // full N-bit magnitude; only the low W bits survive into the output.
  // Negating a zero magnitude yields +0, so no negative zero can appear.
  always_comb begin
    neg     = sa_q ^ sb_q;
    res_q   = qm_next[W-1:0];
    res_ovf = 1'b0;
    if (dz_q) begin
      res_q = sa_q ? Q_MIN : Q_MAX;
    end else if (!neg && (qm_next > {{frac_w{1'b0}}, Q_MAX})) begin
      res_q   = Q_MAX;
      res_ovf = 1'b1;
    end else if (neg && (qm_next > {{frac_w{1'b0}}, Q_MIN})) begin
      res_q   = Q_MIN;
      res_ovf = 1'b1;
    end else if (neg) begin
      res_q = -qm_next[W-1:0];
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (io.in_valid)    state_d = CALC;
      CALC:    if (cnt_q == LAST)  state_d = DONE;
      DONE:    if (io.out_ready)   state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // State register; handshake flags are registered from the next state so
  // they line up with the state they describe.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the datapath is reset along with the control so an aborted
      // operation leaves nothing behind; it is a handful of flops, not memory.
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      mag_b_q    <= '0;
      num_q      <= '0;
      rem_q      <= '0;
      qm_q       <= '0;
      cnt_q      <= '0;
      quotient_q <= '0;
      ovf_q      <= 1'b0;
      dz_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (io.in_valid) begin
            sa_q    <= io.a[W-1];
            sb_q    <= io.b[W-1];
            mag_b_q <= mag_b;
            num_q   <= {mag_a, {frac_w{1'b0}}};
            rem_q   <= '0;
            qm_q    <= '0;
            cnt_q   <= '0;
            dz_q    <= (io.b == '0);
          end
        end
        CALC: begin
          num_q <= {num_q[N-2:0], 1'b0};
          rem_q <= rem_next;
          qm_q  <= qm_next;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            quotient_q <= res_q;
            ovf_q      <= res_ovf;
          end
        end
        default: ;  // DONE: outputs hold until the result is taken
      endcase
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.quotient  = quotient_q;
  assign io.ovf       = ovf_q;
  assign io.dz        = dz_q;

endmodule

// File: doc/fp_div.md
# fp_div

Sequential signed fixed-point divider, the inverse of the `fp_mul` datapath. It accepts a dividend and divisor in the same Q(int_w.frac_w) two's-complement format over a valid/ready handshake. It produces the quotient in that same format with truncation toward zero, saturation, and overflow/divide-by-zero flags. It sits beside `fp_mul` in the fixed-point arithmetic set and is used where a result must be rescaled by a runtime divisor.

## Interface
- `int_w`, default 6: integer bits, sign bit included, of operands and quotient.
- `frac_w`, default 8: fractional bits of operands and quotient.
- Derived: `W = int_w+frac_w`; `N = W+frac_w` (iterations, 22 at defaults).
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `in_valid`  in  1: operands valid.
- `in_ready`  out  1: divider can accept operands.
- `a`  in  W: signed dividend, Q(int_w.frac_w).
- `b`  in  W: signed divisor, Q(int_w.frac_w).
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: downstream accepts the result.
- `quotient`  out  W: signed result, Q(int_w.frac_w).
- `ovf`  out  1: result saturated because it was out of range.
- `dz`  out  1: divisor was zero.

## Operation
- FSM with three states: IDLE, CALC, DONE.
- **Reset** applies from any state, CALC included, and discards any operation in flight. After reset:
  - state = IDLE, `in_ready` = 1, `out_valid` = 0.
  - `quotient` = 0, `ovf` = 0, `dz` = 0.
  - iteration counter = 0.
- **IDLE:** `in_ready` = 1. When `in_valid` && `in_ready` at an edge:
  - latch `sa` = sign(a) and `sb` = sign(b).
  - latch |a| and |b| as unsigned W-bit magnitudes; |−2^(W−1)| = 2^(W−1) is representable.
  - load the numerator N_reg = |a| << frac_w, (W+frac_w) bits wide.
  - clear the remainder and the quotient register; latch `dz` = (b == 0).
  - go to CALC.
- **CALC:** `in_ready` = 0. One restoring-division step per cycle, MSB first:
  - remainder = {remainder, next numerator bit}.
  - if remainder ≥ |b|, subtract |b| and shift in a quotient bit of 1, otherwise shift in 0.
  - after exactly N steps go to DONE, whether or not `dz` is set (constant latency).
- **Result formation** on the CALC→DONE edge, with raw unsigned magnitude Qm of N bits and `neg` = sa ^ sb:
  - if `dz`: `quotient` = 2^(W−1)−1 when `sa` = 0, else −2^(W−1); `ovf` = 0.
  - else if `neg` = 0 and Qm > 2^(W−1)−1: `quotient` = 2^(W−1)−1, `ovf` = 1.
  - else if `neg` = 1 and Qm > 2^(W−1): `quotient` = −2^(W−1), `ovf` = 1.
  - otherwise `quotient` = neg ? −Qm : Qm, `ovf` = 0.
  - a magnitude truncated to zero yields +0, never a negative zero.
- **DONE:** `out_valid` = 1. `quotient`, `ovf` and `dz` hold stable until `out_valid` && `out_ready`, then go to IDLE.
- `in_valid` is ignored outside IDLE, and `a`/`b` may change freely after acceptance.

## Timing
- Accept edge T0 (IDLE, `in_valid` = 1) → CALC.
- CALC steps run on edges T1..TN; `out_valid` rises after edge TN.
- Latency from the accept edge to the first cycle with `out_valid` high is N edges, so results appear N+1 cycles after `in_valid` is first presented in IDLE.
- Handshake at edge TD with `out_ready` = 1 → IDLE; `in_ready` = 1 in the next cycle.
- Minimum throughput: one result per N+2 cycles.
- `out_ready` held low stalls indefinitely in DONE with outputs stable.
- `in_ready` is a registered function of state; there are no combinational paths from inputs to outputs.

## Test plan
All values at defaults (W=14, frac_w=8, 1.0 = 256).
- Basic: a=768 (3.0), b=512 (2.0) → `quotient`=384 (1.5), ovf=0, dz=0; `out_valid` first high N edges (22) after the accept edge.
- Signs: a=−768, b=512 → −384; a=−768, b=−512 → 384; a=1, b=768 → 0 (truncation, positive zero).
- Saturation:
  - a=−8192 (−32.0), b=−256 → 8191, ovf=1.
  - a=−8192, b=256 → −8192, ovf=0 (exact minimum).
  - a=−256, b=3 → −8192, ovf=1.
- Divide by zero: a=256, b=0 → 8191, dz=1, ovf=0; a=−5, b=0 → −8192, dz=1; latency is still N.
- Back-pressure and back-to-back:
  - hold `out_ready`=0 for 10 cycles: `out_valid`, `quotient` and flags remain stable and `in_valid` pulses are ignored.
  - on release, the next operation is accepted in the following cycle.
- Reset mid-operation: assert `reset` at the 10th CALC cycle → next cycle in IDLE with all outputs 0; a fresh 768/512 then completes to 384.
